// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - opcode/handshake inputs and control word of the multicycle control unit
// Optional ILLEGAL_OP_TRAP_EN adds the IllegalOp flag.
interface multicycle_control_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           Op;
  logic                 mem_ready;
  logic                 RegDst;
  logic                 Branch;
  logic                 MemRead;
  logic                 MemToReg;
  logic                 MemToWrite;
  logic [1:0]           AluOp;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic                 RegToWrite;
  logic                 IorD;
  logic                 IRWrite;
  logic                 PCWrite;
  logic [1:0]           PCSrc;
  logic                 Retire;
  logic [CNT_WIDTH-1:0] InstrCount;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                 IllegalOp;

  modport master (
    input  Op, mem_ready,
    output RegDst, Branch, MemRead, MemToReg, MemToWrite, AluOp, ALUSrcA, ALUSrcB,
           RegToWrite, IorD, IRWrite, PCWrite, PCSrc, Retire, InstrCount, IllegalOp
  );

  modport slave (
    output Op, mem_ready,
    input  RegDst, Branch, MemRead, MemToReg, MemToWrite, AluOp, ALUSrcA, ALUSrcB,
           RegToWrite, IorD, IRWrite, PCWrite, PCSrc, Retire, InstrCount, IllegalOp
  );
`else
  modport master (
    input  Op, mem_ready,
    output RegDst, Branch, MemRead, MemToReg, MemToWrite, AluOp, ALUSrcA, ALUSrcB,
           RegToWrite, IorD, IRWrite, PCWrite, PCSrc, Retire, InstrCount
  );

  modport slave (
    output Op, mem_ready,
    input  RegDst, Branch, MemRead, MemToReg, MemToWrite, AluOp, ALUSrcA, ALUSrcB,
           RegToWrite, IorD, IRWrite, PCWrite, PCSrc, Retire, InstrCount
  );
`endif
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for the multicycle MIPS datapath with retired-instruction counter
// Optional ILLEGAL_OP_TRAP_EN: undefined opcodes lock the FSM in TRAP until reset.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  state_t state, state_nxt;

  logic                 reg_dst;
  logic                 branch;
  logic                 mem_read;
  logic                 mem_to_reg;
  logic                 mem_to_write;
  logic [1:0]           alu_op;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 reg_to_write;
  logic                 i_or_d;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic                 retire;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] instr_count;

  // State register; reset aborts any in-flight instruction without a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_RTYPEEX;
          OP_BEQ:       state_nxt = S_BEQEX;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JEX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_nxt = S_TRAP;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      // Op is only LW or SW here; anything else is treated as a load.
      S_MEMADR:  state_nxt = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_nxt = S_FETCH;
      S_MEMWR:   state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_nxt = S_RTYPEWB;
      S_RTYPEWB: state_nxt = S_FETCH;
      S_BEQEX:   state_nxt = S_FETCH;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      S_ADDIWB:  state_nxt = S_FETCH;
      S_JEX:     state_nxt = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:    state_nxt = S_TRAP;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reg_dst      = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_to_reg   = 1'b0;
    mem_to_write = 1'b0;
    alu_op       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    reg_to_write = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    retire       = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg   = 1'b1;
        reg_to_write = 1'b1;
        retire       = 1'b1;
      end
      S_MEMWR: begin
        mem_to_write = 1'b1;
        i_or_d       = 1'b1;
        retire       = bus.mem_ready;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTYPEWB: begin
        reg_dst      = 1'b1;
        reg_to_write = 1'b1;
        retire       = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_to_write = 1'b1;
        retire       = 1'b1;
      end
      S_JEX: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Counter wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  assign bus.RegDst     = reg_dst;
  assign bus.Branch     = branch;
  assign bus.MemRead    = mem_read;
  assign bus.MemToReg   = mem_to_reg;
  assign bus.MemToWrite = mem_to_write;
  assign bus.AluOp      = alu_op;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.RegToWrite = reg_to_write;
  assign bus.IorD       = i_or_d;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.PCSrc      = pc_src;
  assign bus.Retire     = retire;
  assign bus.InstrCount = instr_count;
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.IllegalOp  = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed-vector bench for multicycle_control_fsm (CNT_WIDTH=4)
// Honours ILLEGAL_OP_TRAP_EN when defined.
module tb_multicycle_control_fsm;

  localparam int CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {RegDst,Branch,MemRead,MemToReg,MemToWrite}, AluOp, ALUSrcA, ALUSrcB,
  // {RegToWrite,IorD,IRWrite,PCWrite}, PCSrc, Retire
  localparam logic [16:0] C_IDLE    = 17'h0;
  localparam logic [16:0] C_FETCH_R = {5'b00100, 2'b00, 1'b0, 2'b01, 4'b0011, 2'b00, 1'b0};
  localparam logic [16:0] C_FETCH_S = {5'b00100, 2'b00, 1'b0, 2'b01, 4'b0000, 2'b00, 1'b0};
  localparam logic [16:0] C_DECODE  = {5'b00000, 2'b00, 1'b0, 2'b11, 4'b0000, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMADR  = {5'b00000, 2'b00, 1'b1, 2'b10, 4'b0000, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMRD   = {5'b00100, 2'b00, 1'b0, 2'b00, 4'b0100, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMWB   = {5'b00010, 2'b00, 1'b0, 2'b00, 4'b1000, 2'b00, 1'b1};
  localparam logic [16:0] C_MEMWR_S = {5'b00001, 2'b00, 1'b0, 2'b00, 4'b0100, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMWR_R = {5'b00001, 2'b00, 1'b0, 2'b00, 4'b0100, 2'b00, 1'b1};
  localparam logic [16:0] C_RTEX    = {5'b00000, 2'b10, 1'b1, 2'b00, 4'b0000, 2'b00, 1'b0};
  localparam logic [16:0] C_RTWB    = {5'b10000, 2'b00, 1'b0, 2'b00, 4'b1000, 2'b00, 1'b1};
  localparam logic [16:0] C_BEQEX   = {5'b01000, 2'b01, 1'b1, 2'b00, 4'b0000, 2'b01, 1'b1};
  localparam logic [16:0] C_ADDIEX  = {5'b00000, 2'b00, 1'b1, 2'b10, 4'b0000, 2'b00, 1'b0};
  localparam logic [16:0] C_ADDIWB  = {5'b00000, 2'b00, 1'b0, 2'b00, 4'b1000, 2'b00, 1'b1};
  localparam logic [16:0] C_JEX     = {5'b00000, 2'b00, 1'b0, 2'b00, 4'b0001, 2'b10, 1'b1};

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [16:0] ev [0:15];
  logic        mv [0:15];

  multicycle_control_fsm_if #(.CNT_WIDTH(CW)) bus ();

  multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [16:0] ctrl;
  assign ctrl = {bus.RegDst, bus.Branch, bus.MemRead, bus.MemToReg, bus.MemToWrite,
                 bus.AluOp, bus.ALUSrcA, bus.ALUSrcB,
                 bus.RegToWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
                 bus.PCSrc, bus.Retire};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input int i, input logic [16:0] e, input logic m);
    ev[i] = e;
    mv[i] = m;
  endtask

  // Drive Op/mem_ready for each cycle and compare the state's control word.
  task automatic run(input string nm, input logic [5:0] op, input int n);
    for (int i = 0; i < n; i++) begin
      bus.Op        = op;
      bus.mem_ready = mv[i];
      #1;
      check($sformatf("%s_c%0d", nm, i), 32'(ctrl), 32'(ev[i]));
      tick();
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.Op        = OP_R;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    check("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rst_cnt", 32'(bus.InstrCount), 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
    check("rst_illegal", 32'(bus.IllegalOp), 32'd0);
`endif
    reset = 1'b0;

    // IDLE then LW with no stalls
    ld(0, C_IDLE, 1); ld(1, C_FETCH_R, 1); ld(2, C_DECODE, 1);
    ld(3, C_MEMADR, 1); ld(4, C_MEMRD, 1); ld(5, C_MEMWB, 1);
    run("lw", OP_LW, 6);
    check("lw_cnt", 32'(bus.InstrCount), 32'd1);

    // SW with three stall cycles in MEMWR
    ld(0, C_FETCH_R, 1); ld(1, C_DECODE, 1); ld(2, C_MEMADR, 1);
    ld(3, C_MEMWR_S, 0); ld(4, C_MEMWR_S, 0); ld(5, C_MEMWR_S, 0); ld(6, C_MEMWR_R, 1);
    run("sw", OP_SW, 7);
    check("sw_cnt", 32'(bus.InstrCount), 32'd2);

    // R, BEQ, J, ADDI back-to-back
    ld(0, C_FETCH_R, 1); ld(1, C_DECODE, 1); ld(2, C_RTEX, 1); ld(3, C_RTWB, 1);
    run("r", OP_R, 4);
    ld(0, C_FETCH_R, 1); ld(1, C_DECODE, 1); ld(2, C_BEQEX, 1);
    run("beq", OP_BEQ, 3);
    ld(0, C_FETCH_R, 1); ld(1, C_DECODE, 1); ld(2, C_JEX, 1);
    run("j", OP_J, 3);
    ld(0, C_FETCH_R, 1); ld(1, C_DECODE, 1); ld(2, C_ADDIEX, 1); ld(3, C_ADDIWB, 1);
    run("addi", OP_ADDI, 4);
    check("mix_cnt", 32'(bus.InstrCount), 32'd6);

    // LW stalled in MEMRD, then asynchronous reset mid-cycle
    ld(0, C_FETCH_R, 1); ld(1, C_DECODE, 1); ld(2, C_MEMADR, 1);
    ld(3, C_MEMRD, 0); ld(4, C_MEMRD, 0);
    run("lw_stall", OP_LW, 5);
    #1;
    reset = 1'b1;
    #1;
    check("arst_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("arst_cnt", 32'(bus.InstrCount), 32'd0);
    tick();
    check("arst_hold", 32'(ctrl), 32'(C_IDLE));
    reset = 1'b0;
    ld(0, C_IDLE, 1); ld(1, C_FETCH_R, 1); ld(2, C_DECODE, 1); ld(3, C_JEX, 1);
    run("restart_j", OP_J, 4);
    check("restart_cnt", 32'(bus.InstrCount), 32'd1);

    // Counter wrap at CNT_WIDTH=4
    ld(0, C_FETCH_R, 1); ld(1, C_DECODE, 1); ld(2, C_JEX, 1);
    for (int k = 0; k < 14; k++) run("wrap_j", OP_J, 3);
    check("cnt_15", 32'(bus.InstrCount), 32'd15);
    run("wrap_last", OP_J, 3);
    check("cnt_wrap", 32'(bus.InstrCount), 32'd0);

    // Undefined opcode, with a FETCH stall first
    ld(0, C_FETCH_S, 0); ld(1, C_FETCH_R, 1); ld(2, C_DECODE, 1);
`ifdef ILLEGAL_OP_TRAP_EN
    run("bad", OP_BAD, 3);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("trap_ctrl%0d", k), 32'(ctrl), 32'(C_IDLE));
      check($sformatf("trap_flag%0d", k), 32'(bus.IllegalOp), 32'd1);
      tick();
    end
    reset = 1'b1;
    #1;
    check("trap_rst_flag", 32'(bus.IllegalOp), 32'd0);
    tick();
    reset = 1'b0;
    ld(0, C_IDLE, 1); ld(1, C_FETCH_R, 1);
    run("trap_restart", OP_R, 2);
`else
    ld(3, C_FETCH_R, 1);
    run("bad", OP_BAD, 4);
    check("bad_cnt", 32'(bus.InstrCount), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
